// File: rtl/alu_vector_sequencer.sv
// Operand sequencer for the 6-bit ALU. Two LFSRs produce operand pairs.
// Each pair is held for HOLD_CYCLES cycles. At the end of each hold window
// the ALU result is captured and folded into a running signature.
// Handshake: start is a level request that is only accepted in IDLE. After
// acceptance, busy stays high until the run completes or is aborted.
// result_valid is a single-cycle strobe with no backpressure. done is sticky.
module alu_vector_sequencer #(
  parameter int               WIDTH       = 6,
  parameter int               NUM_VECTORS = 8,
  parameter int               HOLD_CYCLES = 20,
  parameter logic [WIDTH-1:0] SEED_A      = 6'h15,
  parameter logic [WIDTH-1:0] SEED_B      = 6'h2A
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             f_cfg,
  input  logic             x_cfg,
  input  logic             n_cfg,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] input1,
  output logic [WIDTH-1:0] input2,
  output logic             f,
  output logic             x,
  output logic             n,
  output logic             vec_valid,
  output logic [3:0]       vec_index,
  output logic             busy,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] signature,
  output logic             done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(NUM_VECTORS - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? WIDTH'(1) : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? WIDTH'(1) : SEED_B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] hold_cnt;
  logic             launch;
  logic             stop;
  logic             capture;
  logic             last_vec;

  // x^6 + x^5 + 1 step: period 63, never reaches zero from a nonzero state.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q);
    return {q[4:0], q[5] ^ q[4]};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-cycle action strobes. abort outranks capture.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    stop       = 1'b0;
    capture    = 1'b0;
    last_vec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          stop       = 1'b1;
          state_next = ST_IDLE;
        end else if (hold_cnt == CNT_END) begin
          capture = 1'b1;
          if (vec_index == LAST_IDX) begin
            last_vec   = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operands, controls, capture, signature and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      input1       <= '0;
      input2       <= '0;
      f            <= 1'b0;
      x            <= 1'b0;
      n            <= 1'b0;
      vec_valid    <= 1'b0;
      vec_index    <= '0;
      busy         <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      signature    <= '0;
      done         <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      result_valid <= 1'b0;
      if (launch) begin
        input1    <= SEED_A_EFF;
        input2    <= SEED_B_EFF;
        f         <= f_cfg;
        x         <= x_cfg;
        n         <= n_cfg;
        vec_index <= '0;
        hold_cnt  <= '0;
        vec_valid <= 1'b1;
        busy      <= 1'b1;
        done      <= 1'b0;
        signature <= '0;
      end
      if (stop) begin
        vec_valid <= 1'b0;
        busy      <= 1'b0;
      end
      if (state == ST_HOLD && !abort) hold_cnt <= hold_cnt + 1'b1;
      if (capture) begin
        result_out   <= alu_result;
        result_valid <= 1'b1;
        signature    <= {signature[4:0], signature[5] ^ signature[4]} ^ alu_result;
        if (last_vec) begin
          vec_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          input1    <= lfsr_step(input1);
          input2    <= lfsr_step(input2);
          vec_index <= vec_index + 1'b1;
          hold_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Directed bench for alu_vector_sequencer with HOLD_CYCLES=4, NUM_VECTORS=3.
module tb_alu_vector_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, f_cfg, x_cfg, n_cfg;
  logic [5:0] alu_result;
  logic [5:0] input1, input2, result_out, signature;
  logic       f, x, n, vec_valid, busy, result_valid, done;
  logic [3:0] vec_index;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] EXP_A [3] = '{6'h15, 6'h2B, 6'h17};
  localparam logic [5:0] EXP_B [3] = '{6'h2A, 6'h15, 6'h2B};

  alu_vector_sequencer #(
    .WIDTH(6), .NUM_VECTORS(3), .HOLD_CYCLES(4), .SEED_A(6'h15), .SEED_B(6'h2A)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_cfg(f_cfg), .x_cfg(x_cfg), .n_cfg(n_cfg), .alu_result(alu_result),
    .input1(input1), .input2(input2), .f(f), .x(x), .n(n),
    .vec_valid(vec_valid), .vec_index(vec_index), .busy(busy),
    .result_out(result_out), .result_valid(result_valid),
    .signature(signature), .done(done)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] sig_next(input logic [5:0] s, input logic [5:0] r);
    return {s[4:0], s[5] ^ s[4]} ^ r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_in1"}, 8'(input1), 8'h00);
    check({tag, "_in2"}, 8'(input2), 8'h00);
    check({tag, "_fxn"}, 8'({f, x, n}), 8'h00);
    check({tag, "_vv"}, 8'(vec_valid), 8'h00);
    check({tag, "_idx"}, 8'(vec_index), 8'h00);
    check({tag, "_busy"}, 8'(busy), 8'h00);
    check({tag, "_res"}, 8'(result_out), 8'h00);
    check({tag, "_rv"}, 8'(result_valid), 8'h00);
    check({tag, "_sig"}, 8'(signature), 8'h00);
    check({tag, "_done"}, 8'(done), 8'h00);
  endtask

  // Launch a full run from IDLE and check every cycle until DONE.
  // pulse: toggle start mid-run. keep: hold start high throughout.
  task automatic run(input logic [5:0] res, input logic cfg, input bit pulse, input bit keep);
    logic [5:0] sig;
    sig = 6'h00;
    alu_result = res;
    f_cfg = cfg; x_cfg = cfg; n_cfg = cfg;
    start = 1'b1;
    tick();
    start = keep;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 4; c++) begin
        check("in1", 8'(input1), 8'(EXP_A[v]));
        check("in2", 8'(input2), 8'(EXP_B[v]));
        check("idx", 8'(vec_index), 8'(v));
        check("busy", 8'(busy), 8'h01);
        check("vv", 8'(vec_valid), 8'h01);
        check("done_run", 8'(done), 8'h00);
        check("fxn", 8'({f, x, n}), {5'd0, {3{cfg}}});
        check("rv_run", 8'(result_valid), 8'((v > 0) && (c == 0)));
        check("sig_run", 8'(signature), 8'(sig));
        if (c == 1) begin
          f_cfg = ~cfg; x_cfg = ~cfg; n_cfg = ~cfg;
        end
        if (pulse) start = (v == 1) && (c == 1);
        if (c == 3) sig = sig_next(sig, res);
        tick();
      end
    end
    start = keep;
    check("busy_done", 8'(busy), 8'h00);
    check("vv_done", 8'(vec_valid), 8'h00);
    check("done_set", 8'(done), 8'h01);
    check("rv_last", 8'(result_valid), 8'h01);
    check("res_last", 8'(result_out), 8'(res));
    check("sig_final", 8'(signature), 8'(sig));
    check("in1_keep", 8'(input1), 8'h17);
    check("in2_keep", 8'(input2), 8'h2B);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    f_cfg = 1'b0; x_cfg = 1'b0; n_cfg = 1'b0; alu_result = 6'h00;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();
    check_zero("idle");

    // Sequence, signature 1/3/7, cfg latched, start pulse during busy ignored.
    run(6'h01, 1'b1, 1'b1, 1'b0);
    check("sig_137", 8'(signature), 8'h07);
    tick();
    check("done_sticky", 8'(done), 8'h01);
    check("rv_clear", 8'(result_valid), 8'h00);
    check("busy_idle", 8'(busy), 8'h00);
    check("fxn_keep", 8'({f, x, n}), 8'h07);

    // Zero result keeps signature at zero.
    run(6'h00, 1'b0, 1'b0, 1'b0);
    check("sig_zero", 8'(signature), 8'h00);
    tick();

    // Abort at hold cycle 2 of vector 1.
    alu_result = 6'h05;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_done_clr", 8'(done), 8'h00);
    repeat (4) tick();
    check("ab_rv_v0", 8'(result_valid), 8'h01);
    check("ab_sig_v0", 8'(signature), 8'h05);
    check("ab_idx", 8'(vec_index), 8'h01);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 8'(busy), 8'h00);
    check("ab_vv", 8'(vec_valid), 8'h00);
    check("ab_done", 8'(done), 8'h00);
    check("ab_rv", 8'(result_valid), 8'h00);
    check("ab_sig", 8'(signature), 8'h05);
    check("ab_res", 8'(result_out), 8'h05);
    alu_result = 6'h3F;
    repeat (3) tick();
    check("ab_rv_late", 8'(result_valid), 8'h00);
    check("ab_sig_late", 8'(signature), 8'h05);
    check("ab_busy_late", 8'(busy), 8'h00);

    // abort in IDLE has no effect; start with abort in IDLE: start wins.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", 8'(busy), 8'h01);
    check("sa_in1", 8'(input1), 8'h15);
    check("sa_sig", 8'(signature), 8'h00);

    // Reset mid-run clears everything; next run repeats the sequence.
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midreset");
    tick();
    run(6'h01, 1'b0, 1'b0, 1'b0);
    tick();

    // start held high through DONE re-launches a run.
    run(6'h02, 1'b1, 1'b0, 1'b1);
    tick();
    check("relaunch_idle_busy", 8'(busy), 8'h00);
    check("relaunch_idle_done", 8'(done), 8'h01);
    tick();
    start = 1'b0;
    check("relaunch_busy", 8'(busy), 8'h01);
    check("relaunch_done", 8'(done), 8'h00);
    check("relaunch_sig", 8'(signature), 8'h00);
    check("relaunch_in1", 8'(input1), 8'h15);
    check("relaunch_idx", 8'(vec_index), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_vector_sequencer.md
Name: alu_vector_sequencer

Overview:
Upstream stimulus stage for the 6-bit ALU (ports input1, input2, f, x, n, num_or_less_than). It generates a bounded sequence of pseudo-random operand pairs from two LFSRs and holds each pair stable for a programmable number of cycles. At the end of each hold window it captures the ALU result and folds it into a running signature. It replaces free-running $random stimulus with a synthesizable, repeatable sequence usable both on the FPGA and in simulation.

Parameters:
WIDTH, 6, operand/result width (block is specified and verified at 6 only)
NUM_VECTORS, 8, operand pairs per run (1..15)
HOLD_CYCLES, 20, clock cycles each pair is held (>=2)
SEED_A, 6'h15, LFSR A seed (drives input1); 0 is replaced by 6'h01
SEED_B, 6'h2A, LFSR B seed (drives input2); 0 is replaced by 6'h01

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  terminate run, return to IDLE; done not set
f_cfg, x_cfg, n_cfg  in  1 each  ALU control values, latched on accepted start
alu_result  in  6  ALU num_or_less_than output
input1, input2  out  6  operands to ALU
f, x, n  out  1 each  registered ALU controls
vec_valid  out  1  operands currently presented are a live vector
vec_index  out  4  index of current vector, 0..NUM_VECTORS-1
busy  out  1  run in progress
result_out  out  6  last captured alu_result
result_valid  out  1  one-cycle pulse when result_out updates
signature  out  6  running result signature
done  out  1  sticky run-complete flag

Behaviour:
- Reset: state IDLE; all outputs 0 (input1, input2, f, x, n, vec_valid, vec_index, busy, result_out, result_valid, signature, done). Reset has priority over everything and applies mid-run.
- LFSR step (A and B): next = {q[4:0], q[5]^q[4]} (x^6+x^5+1, period 63, never reaches 0).
- States: IDLE, HOLD, DONE.
- IDLE + start: next cycle enters HOLD with input1=SEED_A, input2=SEED_B, f/x/n=cfg, vec_index=0, hold counter=0, vec_valid=1, busy=1, done=0, signature=0.
- HOLD: the hold counter increments every cycle. In the cycle with counter==HOLD_CYCLES-1:
  - result_out<=alu_result, result_valid=1 on the next cycle;
  - signature<={sig[4:0],sig[5]^sig[4]} ^ alu_result.
  - If vec_index==NUM_VECTORS-1, go to DONE. Otherwise step both LFSRs, increment vec_index, and clear the counter, so the new pair appears on the following cycle.
- Each vector is presented for exactly HOLD_CYCLES cycles. Total busy length is NUM_VECTORS*HOLD_CYCLES cycles.
- DONE (one cycle): busy=0, vec_valid=0, done=1, then IDLE. Operands and f/x/n keep their last values. done stays set until the next accepted start or reset.
- start while busy is ignored. start held high in IDLE after DONE launches a new run.
- abort in HOLD: next cycle is IDLE, busy=0, vec_valid=0, no capture that cycle, signature and result_out retained, done unchanged (0). abort takes priority over the capture/advance in the same cycle. abort in IDLE or DONE has no effect.
- start and abort together in IDLE: start wins.

Test Plan:
1. Reset, then start with HOLD_CYCLES=4, NUM_VECTORS=3 -> input1 sequence 0x15, 0x2B, 0x17 and input2 sequence 0x2A, 0x15, 0x2B, each held exactly 4 cycles; busy high 12 cycles; done rises on the cycle after the last hold.
2. Same run with alu_result tied to 6'h01 -> result_valid pulses 3 times, signature 0x01, 0x03, 0x07; with alu_result=0 the signature stays 0x00.
3. f_cfg=1, x_cfg=1, n_cfg=1 at start, then toggle the cfg inputs mid-run -> f=x=n=1 for the entire run.
4. Assert abort in hold cycle 2 of vector 1 -> IDLE next cycle, done=0, result_valid never pulses for vector 1, signature equals the value after vector 0.
5. Assert reset mid-run -> all outputs 0 next cycle. A new start then reproduces the sequence from scenario 1 exactly.
6. Pulse start during busy -> no restart, sequence unaffected. Hold start high through DONE -> second run begins, done clears, signature restarts from 0.
